// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package loader_pkg;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    DONE,
    ERROR
  } ld_state_e;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  localparam int LANE_W     = $clog2(WORD_BYTES);

endpackage

// File: rtl/byte_packer.sv
// Packs consecutive bytes little-endian into 32-bit words and pulses word_vld
// for one cycle after the byte that completes each word.
module byte_packer
  import loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clear,
  input  logic        i_take,
  input  logic [7:0]  i_byte,
  output logic        o_last_lane,
  output logic        o_word_vld,
  output logic [31:0] o_word
);

  logic [LANE_W-1:0]       lane_reg;
  logic [8*WORD_BYTES-1:0] asm_reg;
  logic [8*WORD_BYTES-1:0] asm_next;
  logic [8*WORD_BYTES-1:0] word_reg;
  logic                    vld_reg;

  // Each lane either captures the incoming byte or holds its previous value.
  for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
    assign asm_next[gi*8 +: 8] = (i_take && (lane_reg == LANE_W'(gi))) ?
                                 i_byte : asm_reg[gi*8 +: 8];
  end

  assign o_last_lane = (lane_reg == LANE_W'(WORD_BYTES - 1));

  // The output word is a separate register so the next word can start
  // assembling in the same cycle the previous one is being written.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      lane_reg <= '0;
      asm_reg  <= '0;
      word_reg <= '0;
      vld_reg  <= 1'b0;
    end else if (i_clear) begin
      lane_reg <= '0;
      asm_reg  <= '0;
      vld_reg  <= 1'b0;
    end else begin
      vld_reg <= 1'b0;
      if (i_take) begin
        asm_reg  <= asm_next;
        lane_reg <= lane_reg + 1'b1;
        if (o_last_lane) begin
          vld_reg  <= 1'b1;
          word_reg <= asm_next;
        end
      end
    end
  end

  assign o_word_vld = vld_reg;
  assign o_word     = word_reg;

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checksummed program image into instruction
// memory and holds the core in reset until a verified image is in place.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_restart,
  input  logic              i_byte_vld,
  input  logic [7:0]        i_byte,
  output logic              o_byte_rdy,
  output logic              o_imem_wren,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_core_rst_n,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W:0]   o_word_cnt
);

  localparam int           DEPTH   = 2 ** ADDR_W;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  ld_state_e          state_reg;
  ld_state_e          state_next;
  logic [CNT_W-1:0]   len_reg;
  logic [7:0]         csum_reg;
  logic [ADDR_W:0]    word_cnt_reg;

  logic               xfer;
  logic               take;
  logic               restart_ok;
  logic [CNT_W-1:0]   len_full;
  logic [CNT_W:0]     words_after;
  logic               last_word;

  logic               pk_last_lane;
  logic               pk_word_vld;
  logic [31:0]        pk_word;

  assign xfer       = i_byte_vld & o_byte_rdy;
  assign take       = xfer && (state_reg == DATA);
  assign restart_ok = i_restart && ((state_reg == DONE) || (state_reg == ERROR));
  assign len_full   = CNT_W'({i_byte, len_reg[8*(HDR_BYTES-1)-1:0]});

  // Word count including the word completed by the current lane-3 byte; the
  // previous word's write has always retired by the time lane 3 arrives.
  assign words_after = (CNT_W + 1)'(word_cnt_reg) + 1'b1;
  assign last_word   = (words_after == {1'b0, len_reg});

  byte_packer u_packer (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (restart_ok),
    .i_take      (take),
    .i_byte      (i_byte),
    .o_last_lane (pk_last_lane),
    .o_word_vld  (pk_word_vld),
    .o_word      (pk_word)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg <= LEN_LO;
    end else begin
      state_reg <= state_next;
    end
  end

  // Leaving DATA on the final lane-3 byte lets the checksum byte arrive in
  // the very next cycle, overlapping the last memory write.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LEN_LO: if (xfer) state_next = LEN_HI;
      LEN_HI: begin
        if (xfer) begin
          if ({1'b0, len_full} > DEPTH_C) begin
            state_next = ERROR;
          end else if (len_full == '0) begin
            state_next = CHECK;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: if (take && pk_last_lane && last_word) state_next = CHECK;
      CHECK: begin
        if (xfer) begin
          state_next = (i_byte == csum_reg) ? DONE : ERROR;
        end
      end
      DONE:    if (i_restart) state_next = LEN_LO;
      ERROR:   if (i_restart) state_next = LEN_LO;
      default: state_next = LEN_LO;
    endcase
  end

  always_comb begin
    o_byte_rdy   = 1'b0;
    o_done       = 1'b0;
    o_err        = 1'b0;
    o_core_rst_n = 1'b0;
    case (state_reg)
      LEN_LO, LEN_HI, DATA, CHECK: o_byte_rdy = 1'b1;
      DONE: begin
        o_done       = 1'b1;
        o_core_rst_n = 1'b1;
      end
      ERROR:   o_err = 1'b1;
      default: o_byte_rdy = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      len_reg      <= '0;
      csum_reg     <= '0;
      word_cnt_reg <= '0;
    end else if (restart_ok) begin
      csum_reg     <= '0;
      word_cnt_reg <= '0;
    end else begin
      if (xfer && (state_reg == LEN_LO)) len_reg[7:0] <= i_byte;
      if (xfer && (state_reg == LEN_HI)) len_reg      <= len_full;
      if (take)                          csum_reg     <= csum_reg ^ i_byte;
      if (pk_word_vld)                   word_cnt_reg <= word_cnt_reg + 1'b1;
    end
  end

  assign o_imem_wren  = pk_word_vld;
  assign o_imem_addr  = word_cnt_reg[ADDR_W-1:0];
  assign o_imem_wdata = pk_word;
  assign o_word_cnt   = word_cnt_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: each task loads or corrupts an
// image and compares handshake, memory writes and status against fixed values.
module tb_imem_loader;

  localparam int ADDR_W = 11;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              restart;
  logic              byte_vld;
  logic [7:0]        byte_d;
  logic              byte_rdy;
  logic              imem_wren;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst_n;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   word_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0]       img [0:3];
  logic [ADDR_W-1:0] wa_q [$];
  logic [31:0]       wd_q [$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W), .CNT_W(16)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_restart    (restart),
    .i_byte_vld   (byte_vld),
    .i_byte       (byte_d),
    .o_byte_rdy   (byte_rdy),
    .o_imem_wren  (imem_wren),
    .o_imem_addr  (imem_addr),
    .o_imem_wdata (imem_wdata),
    .o_core_rst_n (core_rst_n),
    .o_done       (done),
    .o_err        (err),
    .o_word_cnt   (word_cnt)
  );

  always @(negedge clk) begin
    if (imem_wren) begin
      wa_q.push_back(imem_addr);
      wd_q.push_back(imem_wdata);
      $display("write addr=%0d data=%08h", imem_addr, imem_wdata);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    restart  = 1'b0;
    byte_vld = 1'b0;
    byte_d   = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    restart = 1'b1;
    @(posedge clk);
    #1 restart = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int g = 0; g < gap; g++) @(negedge clk);
    @(negedge clk);
    byte_vld = 1'b1;
    byte_d   = b;
    checks++;
    if (byte_rdy !== 1'b1) begin
      errors++;
      $display("FAIL rdy_before_byte got=%b want=1 byte=%02h", byte_rdy, b);
    end
    @(posedge clk);
    #1 byte_vld = 1'b0;
  endtask

  task automatic load_image(input int n, input logic [7:0] cs, input int maxgap,
                            input logic expect_ok);
    logic [15:0] len;
    len = 16'(n);
    wa_q.delete();
    wd_q.delete();
    send_byte(len[7:0], 0);
    send_byte(len[15:8], 0);
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < 4; k++) begin
        send_byte(img[w][8*k +: 8], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
      end
    end
    @(negedge clk);
    byte_vld = 1'b1;
    byte_d   = cs;
    checks++;
    if (core_rst_n !== 1'b0) begin
      errors++;
      $display("FAIL core_rst_during_load got=%b want=0", core_rst_n);
    end
    @(posedge clk);
    #1 byte_vld = 1'b0;
    @(negedge clk);
    checks++;
    if (core_rst_n !== expect_ok || done !== expect_ok || err !== !expect_ok) begin
      errors++;
      $display("FAIL status_after_checksum core_rst_n=%b done=%b err=%b want_ok=%b",
               core_rst_n, done, err, expect_ok);
    end
    $display("load len=%0d cs=%02h core_rst_n=%b done=%b err=%b", n, cs, core_rst_n, done, err);
  endtask

  task automatic check_writes(input int n);
    checks++;
    if (wa_q.size() != n) begin
      errors++;
      $display("FAIL write_count got=%0d want=%0d", wa_q.size(), n);
    end
    for (int i = 0; i < n && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== ADDR_W'(i) || wd_q[i] !== img[i]) begin
        errors++;
        $display("FAIL write_%0d got addr=%0d data=%08h want addr=%0d data=%08h",
                 i, wa_q[i], wd_q[i], i, img[i]);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (byte_rdy !== 1'b1 || imem_wren !== 1'b0 || imem_addr !== '0 || imem_wdata !== '0 ||
        core_rst_n !== 1'b0 || done !== 1'b0 || err !== 1'b0 || word_cnt !== '0) begin
      errors++;
      $display("FAIL reset_state rdy=%b wren=%b addr=%0d wdata=%08h core=%b done=%b err=%b cnt=%0d",
               byte_rdy, imem_wren, imem_addr, imem_wdata, core_rst_n, done, err, word_cnt);
    end
    $display("reset rdy=%b core_rst_n=%b cnt=%0d", byte_rdy, core_rst_n, word_cnt);
  endtask

  task automatic test_basic();
    img[0] = 32'h0000_0013;
    img[1] = 32'h0010_0093;
    load_image(2, 8'h90, 0, 1'b1);
    checks++;
    if (word_cnt !== 12'd2 || byte_rdy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done cnt=%0d rdy=%b want cnt=2 rdy=0", word_cnt, byte_rdy);
    end
    check_writes(2);
  endtask

  task automatic test_restart();
    pulse_restart();
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || word_cnt !== '0 || core_rst_n !== 1'b0 || byte_rdy !== 1'b1) begin
      errors++;
      $display("FAIL restart_clear done=%b cnt=%0d core=%b rdy=%b", done, word_cnt, core_rst_n, byte_rdy);
    end
    img[0] = 32'h0000_0073;
    load_image(1, 8'h73, 0, 1'b1);
    check_writes(1);
  endtask

  task automatic test_bad_checksum();
    pulse_restart();
    img[0] = 32'h0000_0013;
    img[1] = 32'h0010_0093;
    load_image(2, 8'h80, 0, 1'b0);
    checks++;
    if (byte_rdy !== 1'b0 || word_cnt !== 12'd2 || core_rst_n !== 1'b0) begin
      errors++;
      $display("FAIL bad_cs_state rdy=%b cnt=%0d core=%b", byte_rdy, word_cnt, core_rst_n);
    end
    check_writes(2);
  endtask

  task automatic test_overflow();
    pulse_restart();
    wa_q.delete();
    wd_q.delete();
    send_byte(8'h01, 0);
    send_byte(8'h08, 0);
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || byte_rdy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL overflow_err err=%b rdy=%b done=%b", err, byte_rdy, done);
    end
    byte_vld = 1'b1;
    byte_d   = 8'h55;
    repeat (6) @(negedge clk);
    byte_vld = 1'b0;
    check_writes(0);
    $display("overflow err=%b writes=%0d", err, wa_q.size());
  endtask

  task automatic test_max_len();
    do_reset();
    wa_q.delete();
    wd_q.delete();
    send_byte(8'h00, 0);
    send_byte(8'h08, 0);
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || byte_rdy !== 1'b1) begin
      errors++;
      $display("FAIL max_len_accepted err=%b rdy=%b", err, byte_rdy);
    end
    img[0] = 32'hCAFE_F00D;
    for (int k = 0; k < 4; k++) send_byte(img[0][8*k +: 8], 0);
    repeat (2) @(negedge clk);
    check_writes(1);
    do_reset();
  endtask

  task automatic test_zero_len();
    load_image(0, 8'h00, 0, 1'b1);
    checks++;
    if (word_cnt !== '0) begin
      errors++;
      $display("FAIL zero_len_cnt got=%0d want=0", word_cnt);
    end
    check_writes(0);
  endtask

  task automatic test_gaps();
    pulse_restart();
    img[0] = 32'h0000_0013;
    img[1] = 32'h0010_0093;
    load_image(2, 8'h90, 3, 1'b1);
    check_writes(2);
  endtask

  task automatic test_reset_mid();
    pulse_restart();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int k = 0; k < 5; k++) send_byte(8'hA0 + 8'(k), 0);
    do_reset();
    checks++;
    if (word_cnt !== '0 || byte_rdy !== 1'b1 || core_rst_n !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_state cnt=%0d rdy=%b core=%b err=%b", word_cnt, byte_rdy, core_rst_n, err);
    end
    img[0] = 32'hDEAD_BEEF;
    img[1] = 32'h1234_5678;
    img[2] = 32'hA5A5_A5A5;
    load_image(3, 8'h2A, 1, 1'b1);
    checks++;
    if (word_cnt !== 12'd3) begin
      errors++;
      $display("FAIL mid_reset_cnt got=%0d want=3", word_cnt);
    end
    check_writes(3);
  endtask

  initial begin
    rst_n    = 1'b0;
    restart  = 1'b0;
    byte_vld = 1'b0;
    byte_d   = 8'h00;
    test_reset();
    test_basic();
    test_restart();
    test_bad_checksum();
    test_overflow();
    test_max_len();
    test_zero_len();
    test_gaps();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
